tl_d_trace_capture: RTL and testbench
=====================================

# tl_d_trace_capture

Parametrised TileLink D-channel trace capture for the hart-0 Insight trace path. Passively snoops a D-channel handshake (never drives `d_ready`), tags each fired beat with burst position and gap information, and buffers it in a DEPTH-entry FIFO toward the trace encoder. Checks multi-beat burst consistency and reports drops and protocol errors.

## Interface
- `DATA_W`, 32, D data width in bits; power of 2, at least 8.
- `SOURCE_W`, 1, `d_source` width.
- `SINK_W`, 1, `d_sink` width.
- `SIZE_W`, 4, `d_size` width (log2 bytes).
- `DEPTH`, 8, FIFO entries; power of 2, at least 2.
- `CNT_W`, 16, drop counter width.

Ports:
- `clock` in 1: single clock. Reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `d_valid`, `d_ready` in 1: observed handshake. A beat fires when both are 1.
- `d_opcode` in 3, `d_param` in 2, `d_size` in SIZE_W, `d_source` in SOURCE_W, `d_sink` in SINK_W, `d_denied` in 1, `d_corrupt` in 1, `d_data` in DATA_W: observed D-channel beat fields.
- `out_valid` out 1, `out_ready` in 1: trace output handshake.
- `out_entry` out width of `trace_entry_t`: captured fields plus `first`, `last`, `beat_idx` (SIZE_W bits) and `gap`.
- `drop_count` out CNT_W: beats dropped because the FIFO was full. Saturates.
- `proto_err` out 1: sticky protocol-error flag.
- `clear` in 1: zeroes `drop_count` and `proto_err`. The FIFO is not flushed.

## Operation
- **Fire:** `d_valid & d_ready`.
- **Beats per message:**
  - Opcodes 1 (AccessAckData) and 5 (GrantData): beats = max(1, 2^d_size / (DATA_W/8)).
  - All other opcodes: 1 beat.
  - Compute as a shift; no divider.
- **FSM:**
  - IDLE → BURST on a fire whose beat count exceeds 1. Latch opcode, size and source; set beat_idx to 1.
  - In BURST, each fire increments beat_idx. The last beat (beat_idx == beats-1) returns to IDLE.
  - A first beat has first=1 only in IDLE. The last beat has last=1. A single-beat message has first=last=1.
- **Protocol errors:** `proto_err` is set by any of:
  - opcode 3 or 7;
  - a BURST beat whose opcode, size or source differs from the latched values;
  - `d_corrupt`=1 with an opcode that carries no data.
  - The erroneous beat is still captured. The FSM follows that beat's own fields.
- **Push:** each fire pushes one entry.
  - If the FIFO is full and no pop occurs in the same cycle, drop the beat, increment `drop_count` (saturating), and set the pending-gap flag.
  - A burst beat that is dropped still advances the FSM.
- **Gap:** the next pushed entry carries gap=1, then the pending-gap flag clears.
- **Pop:** `out_valid & out_ready`.
- **Simultaneous push and pop when full:** both occur, no drop.
- **Simultaneous `clear` and drop:** `drop_count` becomes 0, not 1.

## Timing
- Capture-to-output latency is 1 cycle: a fire in cycle N into an empty FIFO gives `out_valid`=1 in N+1. No combinational path from `d_*` to `out_*`.
- `out_entry` is stable while `out_valid & !out_ready`.
- `out_ready` has no combinational effect on the capture side, except the same-cycle full push/pop rule above.
- **Reset values:**
  - `out_valid`=0, `out_entry`=0, `drop_count`=0, `proto_err`=0;
  - FSM in IDLE, pending gap=0, pointers 0.
  - A fire in the reset cycle is ignored.
- **Reset mid-burst:** returns to IDLE. The next fire is treated as a first beat and does not raise `proto_err`.
- **Pointers:** log2(DEPTH)+1 bits. Full/empty uses wrap-bit compare; pointers wrap naturally.

## Structure
- **`tl_d_trace_pkg`:**
  - opcode enum `tl_d_opcode_e` (0 AccessAck, 1 AccessAckData, 2 HintAck, 4 Grant, 5 GrantData, 6 ReleaseAck);
  - function `has_data()`;
  - parametrised `trace_entry_t` layout helper.
- **Sub-module `tl_trace_fifo`:** generic synchronous FIFO (WIDTH, DEPTH) with registered output and same-cycle full push/pop. The top holds the FSM, checks, counters and gap logic.

## Test plan
- **Single-beat:** AccessAck, source 1, fire in cycle 5 → `out_valid` in cycle 6; entry opcode 0, first=1, last=1, beat_idx 0, gap=0.
- **Burst:** AccessAckData, size 4, DATA_W 32 → 4 entries with beat_idx 0-3; first only on idx 0, last only on idx 3; `proto_err`=0.
- **Overflow:** DEPTH 8, `out_ready`=0, 10 fires → 8 entries; `drop_count`=2. Raise `out_ready` and fire once more → entry 9 has gap=1.
- **Full push/pop:** FIFO full with `out_ready`=1 and a fire in the same cycle → no drop, occupancy stays 8.
- **Protocol errors:** source changes mid-burst → `proto_err`=1 and remains set. Opcode 7 → `proto_err`=1. `clear` pulse → both `proto_err` and `drop_count` return to 0.
- **Reset mid-burst:** reset after beat 1 of 4 → the next AccessAckData is captured with first=1 and no `proto_err`.

Source files
------------

// File: rtl/tl_d_trace_capture_pkg.sv
// Shared types and helpers for the TileLink D-channel trace capture path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package tl_d_trace_pkg;

    typedef enum logic [2:0] {
        TL_ACCESS_ACK      = 3'd0,
        TL_ACCESS_ACK_DATA = 3'd1,
        TL_HINT_ACK        = 3'd2,
        TL_GRANT           = 3'd4,
        TL_GRANT_DATA      = 3'd5,
        TL_RELEASE_ACK     = 3'd6
    } tl_d_opcode_e;

    // Only the data-carrying responses can span more than one beat.
    function automatic logic has_data(input logic [2:0] op);
        return (op == TL_ACCESS_ACK_DATA) || (op == TL_GRANT_DATA);
    endfunction

    // Encodings 3 and 7 are not defined on the D channel.
    function automatic logic is_illegal_opcode(input logic [2:0] op);
        return (op == 3'd3) || (op == 3'd7);
    endfunction

    // Width of one trace entry. Layout, MSB first:
    // opcode(3) param(2) size(SIZE_W) source(SOURCE_W) sink(SINK_W) denied corrupt
    // data(DATA_W) first last beat_idx(SIZE_W) gap
    function automatic int trace_entry_width(input int data_w, input int source_w,
                                             input int sink_w, input int size_w);
        return 3 + 2 + size_w + source_w + sink_w + 2 + data_w + 2 + size_w + 1;
    endfunction

endpackage

// File: rtl/tl_d_trace_capture_fifo.sv
// Generic synchronous FIFO; ports: push/push_data/full (write), pop/valid/data (read).
// Latency: a push into an empty FIFO is visible on valid/data the next cycle.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module tl_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             pop_en;
    logic             push_en;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_en  = pop & ~empty;
    // A pop frees the slot this cycle, so a full FIFO can still take the push.
    assign push_en = push & (~full | pop_en);

    assign valid = ~empty;
    // Masked so the output reads zero whenever nothing is held.
    assign data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/tl_d_trace_capture.sv
// Passive TileLink D-channel snooper: tags fired beats (first/last/beat_idx/gap) into a trace FIFO.
// Latency: a fire in cycle N into an empty FIFO shows as out_valid in cycle N+1.
// Backpressure: never stalls d_*; beats arriving while the FIFO is full are dropped and counted.
// Ports: clock/reset; d_* observed beat; out_valid/out_ready/out_entry trace output;
// drop_count, proto_err status; clear zeroes the status.
module tl_d_trace_capture
    import tl_d_trace_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int SOURCE_W = 1,
    parameter  int SINK_W   = 1,
    parameter  int SIZE_W   = 4,
    parameter  int DEPTH    = 8,
    parameter  int CNT_W    = 16,
    localparam int ENTRY_W  = trace_entry_width(DATA_W, SOURCE_W, SINK_W, SIZE_W)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                d_valid,
    input  logic                d_ready,
    input  logic [2:0]          d_opcode,
    input  logic [1:0]          d_param,
    input  logic [SIZE_W-1:0]   d_size,
    input  logic [SOURCE_W-1:0] d_source,
    input  logic [SINK_W-1:0]   d_sink,
    input  logic                d_denied,
    input  logic                d_corrupt,
    input  logic [DATA_W-1:0]   d_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ENTRY_W-1:0]  out_entry,
    output logic [CNT_W-1:0]    drop_count,
    output logic                proto_err,
    input  logic                clear
);

    typedef struct packed {
        logic [2:0]          opcode;
        logic [1:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [SINK_W-1:0]   sink;
        logic                denied;
        logic                corrupt;
        logic [DATA_W-1:0]   data;
        logic                first;
        logic                last;
        logic [SIZE_W-1:0]   beat_idx;
        logic                gap;
    } trace_entry_t;

    // The largest message (2^(2^SIZE_W - 1) bytes) needs this many bits of beat count.
    localparam int                BCNT_W       = 2 ** SIZE_W;
    localparam int                BEAT_SHIFT   = $clog2(DATA_W / 8);
    localparam logic [SIZE_W-1:0] BEAT_SHIFT_S = SIZE_W'(BEAT_SHIFT);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_e;

    // Beats in the message minus one, computed as a shift of the byte count.
    function automatic logic [BCNT_W-1:0] beats_m1(input logic [2:0] op,
                                                   input logic [SIZE_W-1:0] size);
        logic [BCNT_W-1:0] bytes;
        bytes       = '0;
        bytes[size] = 1'b1;
        if (!has_data(op) || (size <= BEAT_SHIFT_S)) begin
            return '0;
        end
        return (bytes >> BEAT_SHIFT) - BCNT_W'(1);
    endfunction

    state_e              state;
    logic [2:0]          lat_op;
    logic [SIZE_W-1:0]   lat_size;
    logic [SOURCE_W-1:0] lat_src;
    logic [BCNT_W-1:0]   beat_cnt;
    logic                gap_pend;

    logic                fire;
    logic                in_burst;
    logic [BCNT_W-1:0]   cur_m1;
    logic [BCNT_W-1:0]   cur_idx;
    logic                is_last;
    logic                mismatch;
    logic                bad_beat;
    logic                pop;
    logic                fifo_full;
    logic                drop;
    logic                push;
    trace_entry_t        entry;

    assign fire     = d_valid & d_ready;
    assign in_burst = (state == S_BURST);
    assign cur_m1   = beats_m1(d_opcode, d_size);
    assign cur_idx  = in_burst ? beat_cnt : '0;
    // >= rather than == so a beat whose own fields imply a shorter message
    // still terminates the burst instead of leaving the FSM stranded.
    assign is_last  = (cur_idx >= cur_m1);
    assign mismatch = in_burst && ((d_opcode != lat_op) || (d_size != lat_size) ||
                                   (d_source != lat_src));
    assign bad_beat = is_illegal_opcode(d_opcode) | mismatch |
                      (d_corrupt & ~has_data(d_opcode));

    assign pop  = out_valid & out_ready;
    assign drop = fire & fifo_full & ~pop;
    assign push = fire & ~drop;

    always_comb begin
        entry          = '0;
        entry.opcode   = d_opcode;
        entry.param    = d_param;
        entry.size     = d_size;
        entry.source   = d_source;
        entry.sink     = d_sink;
        entry.denied   = d_denied;
        entry.corrupt  = d_corrupt;
        entry.data     = d_data;
        entry.first    = ~in_burst;
        entry.last     = is_last;
        entry.beat_idx = cur_idx[SIZE_W-1:0];
        entry.gap      = gap_pend;
    end

    // Burst tracker. Every fired beat advances it, dropped or not, and it
    // re-latches the beat's own fields so an erroneous beat steers what follows.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            lat_op   <= '0;
            lat_size <= '0;
            lat_src  <= '0;
            beat_cnt <= '0;
        end else if (fire) begin
            if (is_last) begin
                state    <= S_IDLE;
                beat_cnt <= '0;
            end else begin
                state    <= S_BURST;
                beat_cnt <= cur_idx + BCNT_W'(1);
                lat_op   <= d_opcode;
                lat_size <= d_size;
                lat_src  <= d_source;
            end
        end
    end

    // Status: clear has priority, so a clear coinciding with a drop leaves zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_count <= '0;
            proto_err  <= 1'b0;
            gap_pend   <= 1'b0;
        end else begin
            if (clear) begin
                proto_err <= 1'b0;
            end else if (fire && bad_beat) begin
                proto_err <= 1'b1;
            end

            if (clear) begin
                drop_count <= '0;
            end else if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_W'(1);
            end

            if (drop) begin
                gap_pend <= 1'b1;
            end else if (push) begin
                gap_pend <= 1'b0;
            end
        end
    end

    tl_trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (entry),
        .full      (fifo_full),
        .pop       (pop),
        .valid     (out_valid),
        .data      (out_entry)
    );

endmodule

// File: tb/tb_tl_d_trace_capture.sv
`timescale 1ns/1ps
module tb_tl_d_trace_capture;
    import tl_d_trace_pkg::*;

    localparam int DATA_W = 32, SOURCE_W = 1, SINK_W = 1, SIZE_W = 4, DEPTH = 8, CNT_W = 16;
    localparam int ENTRY_W = 3 + 2 + SIZE_W + SOURCE_W + SINK_W + 2 + DATA_W + 2 + SIZE_W + 1;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [3:0]  size;
        logic        source;
        logic        sink;
        logic        denied;
        logic        corrupt;
        logic [31:0] data;
        logic        first;
        logic        last;
        logic [3:0]  beat_idx;
        logic        gap;
    } entry_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic d_valid = 0, d_ready = 0, d_denied = 0, d_corrupt = 0;
    logic [2:0] d_opcode = 0;
    logic [1:0] d_param = 0;
    logic [3:0] d_size = 0;
    logic d_source = 0, d_sink = 0;
    logic [31:0] d_data = 0;
    logic out_valid, out_ready = 0, proto_err, clear = 0;
    logic [ENTRY_W-1:0] out_entry;
    logic [CNT_W-1:0] drop_count;

    tl_d_trace_capture dut (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_ready(d_ready),
        .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
        .d_sink(d_sink), .d_denied(d_denied), .d_corrupt(d_corrupt), .d_data(d_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_entry(out_entry),
        .drop_count(drop_count), .proto_err(proto_err), .clear(clear)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        d_valid = 0; d_ready = 0; d_corrupt = 0;
    endtask

    task automatic beat(input logic [2:0] op, input logic [3:0] size, input logic src,
                        input logic cor, input logic [31:0] data);
        d_valid = 1; d_ready = 1; d_opcode = op; d_size = size; d_source = src;
        d_corrupt = cor; d_data = data; d_param = 0; d_sink = 0; d_denied = 0;
    endtask

    function automatic entry_t mk(input logic [2:0] op, input logic [3:0] size, input logic src,
                                  input logic cor, input logic [31:0] data, input logic first,
                                  input logic last, input logic [3:0] idx, input logic gap);
        entry_t e;
        e = '0;
        e.opcode = op; e.size = size; e.source = src; e.corrupt = cor; e.data = data;
        e.first = first; e.last = last; e.beat_idx = idx; e.gap = gap;
        return e;
    endfunction

    function automatic int n_beats(input logic [2:0] op, input int size);
        int b;
        if (op != 3'd1 && op != 3'd5) return 1;
        b = (1 << size) / (DATA_W / 8);
        return (b < 1) ? 1 : b;
    endfunction

    typedef struct {
        logic [2:0] op; logic [3:0] size; logic src; logic cor;
        logic first; logic last; logic [3:0] idx; logic perr;
    } vec_t;

    initial begin
        vec_t vt[$];
        entry_t e;
        int exp_d[$];

        // ---------------- reset; a fire during reset is ignored
        idle();
        tick(); tick();
        beat(3'd0, 4'd2, 1'b0, 1'b0, 32'hdead);
        tick();
        reset = 0;
        idle();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_entry", out_entry, 0);
        chk("reset_drop_count", drop_count, 0);
        chk("reset_proto_err", proto_err, 0);
        tick(); tick(); tick();

        // ---------------- single beat, one cycle latency
        beat(3'd0, 4'd2, 1'b1, 1'b0, 32'h1234_5678);
        chk("single_pre_valid", out_valid, 0);
        tick();
        idle();
        chk("single_valid", out_valid, 1);
        chk("single_entry", out_entry, mk(3'd0, 4'd2, 1'b1, 1'b0, 32'h1234_5678, 1, 1, 0, 0));
        out_ready = 1;
        tick();
        chk("single_drained", out_valid, 0);

        // ---------------- table-driven beats (FIFO drained between vectors)
        vt.push_back('{3'd0, 4'd2, 1'b1, 1'b0, 1, 1, 4'd0, 0});
        vt.push_back('{3'd1, 4'd2, 1'b0, 1'b0, 1, 1, 4'd0, 0});
        vt.push_back('{3'd1, 4'd4, 1'b0, 1'b0, 1, 0, 4'd0, 0});
        vt.push_back('{3'd1, 4'd4, 1'b0, 1'b0, 0, 0, 4'd1, 0});
        vt.push_back('{3'd1, 4'd4, 1'b0, 1'b0, 0, 0, 4'd2, 0});
        vt.push_back('{3'd1, 4'd4, 1'b0, 1'b0, 0, 1, 4'd3, 0});
        vt.push_back('{3'd5, 4'd3, 1'b1, 1'b0, 1, 0, 4'd0, 0});
        vt.push_back('{3'd5, 4'd3, 1'b1, 1'b0, 0, 1, 4'd1, 0});
        vt.push_back('{3'd3, 4'd0, 1'b0, 1'b0, 1, 1, 4'd0, 1});
        vt.push_back('{3'd7, 4'd2, 1'b0, 1'b0, 1, 1, 4'd0, 1});
        vt.push_back('{3'd0, 4'd0, 1'b0, 1'b1, 1, 1, 4'd0, 1});
        vt.push_back('{3'd1, 4'd0, 1'b0, 1'b1, 1, 1, 4'd0, 0});
        vt.push_back('{3'd2, 4'd5, 1'b1, 1'b0, 1, 1, 4'd0, 0});
        vt.push_back('{3'd4, 4'd4, 1'b0, 1'b0, 1, 1, 4'd0, 0});
        vt.push_back('{3'd6, 4'd6, 1'b1, 1'b0, 1, 1, 4'd0, 0});
        foreach (vt[i]) begin
            logic [31:0] dv;
            dv = $urandom;
            beat(vt[i].op, vt[i].size, vt[i].src, vt[i].cor, dv);
            tick();
            idle();
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_entry", i), out_entry,
                mk(vt[i].op, vt[i].size, vt[i].src, vt[i].cor, dv,
                   vt[i].first, vt[i].last, vt[i].idx, 0));
            chk($sformatf("vec%0d_proto_err", i), proto_err, vt[i].perr);
            clear = 1;
            tick();
            clear = 0;
        end

        // ---------------- overflow: 10 fires into a stalled FIFO
        out_ready = 0;
        for (int k = 0; k < 10; k++) begin
            beat(3'd0, 4'd0, 1'b0, 1'b0, k);
            tick();
        end
        idle();
        chk("ovf_drop_count", drop_count, 2);
        chk("ovf_head", out_entry, mk(3'd0, 4'd0, 1'b0, 1'b0, 0, 1, 1, 0, 0));
        // full FIFO, pop and push in the same cycle: no drop
        out_ready = 1;
        beat(3'd0, 4'd0, 1'b0, 1'b0, 10);
        tick();
        idle();
        chk("pushpop_drop_count", drop_count, 2);
        exp_d = '{1, 2, 3, 4, 5, 6, 7, 10};
        foreach (exp_d[k]) begin
            chk($sformatf("ovf_drain%0d_valid", k), out_valid, 1);
            chk($sformatf("ovf_drain%0d_entry", k), out_entry,
                mk(3'd0, 4'd0, 1'b0, 1'b0, exp_d[k], 1, 1, 0, (exp_d[k] == 10)));
            tick();
        end
        chk("ovf_occupancy_8", out_valid, 0);

        // ---------------- source change mid-burst, sticky error, clear
        beat(3'd1, 4'd4, 1'b0, 1'b0, 0); tick();
        chk("burst_beat0_no_err", proto_err, 0);
        beat(3'd1, 4'd4, 1'b1, 1'b0, 1); tick();
        chk("src_change_err", proto_err, 1);
        beat(3'd1, 4'd4, 1'b1, 1'b0, 2); tick();
        beat(3'd1, 4'd4, 1'b1, 1'b0, 3); tick();
        idle();
        tick(); tick(); tick();
        chk("err_sticky", proto_err, 1);
        clear = 1; tick(); clear = 0;
        chk("clear_proto_err", proto_err, 0);
        chk("clear_drop_count", drop_count, 0);
        beat(3'd7, 4'd0, 1'b0, 1'b0, 0); tick();
        idle();
        chk("opcode7_err", proto_err, 1);
        clear = 1; tick(); clear = 0;
        tick(); tick();

        // ---------------- clear coinciding with a drop
        out_ready = 0;
        for (int k = 0; k < 8; k++) begin
            beat(3'd0, 4'd0, 1'b0, 1'b0, k); tick();
        end
        clear = 1;
        tick();
        clear = 0;
        chk("clear_drop_same_cycle", drop_count, 0);
        tick();
        idle();
        chk("drop_after_clear", drop_count, 1);
        clear = 1; tick(); clear = 0;
        chk("clear_again", drop_count, 0);
        out_ready = 1;
        for (int k = 0; k < 10; k++) tick();

        // ---------------- reset mid-burst
        beat(3'd1, 4'd4, 1'b0, 1'b0, 0); tick();
        beat(3'd1, 4'd4, 1'b0, 1'b0, 1); tick();
        idle();
        reset = 1; tick(); reset = 0;
        beat(3'd1, 4'd4, 1'b1, 1'b0, 32'hbeef); tick();
        idle();
        chk("rst_burst_entry", out_entry, mk(3'd1, 4'd4, 1'b1, 1'b0, 32'hbeef, 1, 0, 0, 0));
        chk("rst_burst_no_err", proto_err, 0);

        // ---------------- randomized traffic against a message-level model
        reset = 1; tick(); tick(); reset = 0;
        begin
            entry_t mq[$];
            entry_t bq[$];
            int exp_drop;
            logic exp_perr, gap_pend, fire, pop;
            logic [2:0] ops[7];
            exp_drop = 0; exp_perr = 0; gap_pend = 0;
            ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd1};
            for (int cyc = 0; cyc < 2000; cyc++) begin
                chk("rnd_valid", out_valid, (mq.size() > 0));
                if (mq.size() > 0) chk("rnd_entry", out_entry, mq[0]);
                chk("rnd_drop_count", drop_count, exp_drop);
                chk("rnd_proto_err", proto_err, exp_perr);

                if (bq.size() == 0 && $urandom_range(3) == 0) begin
                    logic [2:0] op;
                    int sz, n;
                    logic src;
                    op  = ($urandom_range(49) == 0) ? 3'd7 : ops[$urandom_range(6)];
                    sz  = $urandom_range(5);
                    src = $urandom_range(1);
                    n   = n_beats(op, sz);
                    for (int k = 0; k < n; k++) begin
                        e = '0;
                        e.opcode = op; e.size = sz; e.source = src;
                        e.param = $urandom; e.sink = $urandom; e.denied = $urandom;
                        e.corrupt = (op == 3'd1 || op == 3'd5) ? 1'($urandom) : 1'b0;
                        e.data = $urandom;
                        e.first = (k == 0); e.last = (k == n - 1); e.beat_idx = k;
                        bq.push_back(e);
                    end
                end

                d_valid = (bq.size() > 0) && ($urandom_range(2) != 0);
                d_ready = ($urandom_range(3) != 0);
                if (bq.size() > 0) begin
                    d_opcode = bq[0].opcode; d_param = bq[0].param; d_size = bq[0].size;
                    d_source = bq[0].source; d_sink = bq[0].sink; d_denied = bq[0].denied;
                    d_corrupt = bq[0].corrupt; d_data = bq[0].data;
                end
                out_ready = ($urandom_range(99) < (((cyc / 250) % 2) ? 85 : 25));

                fire = d_valid & d_ready;
                pop  = (mq.size() > 0) && out_ready;
                if (pop) void'(mq.pop_front());
                if (fire) begin
                    e = bq.pop_front();
                    if (e.opcode == 3'd7) exp_perr = 1;
                    if (mq.size() < DEPTH) begin
                        e.gap = gap_pend;
                        gap_pend = 0;
                        mq.push_back(e);
                    end else begin
                        exp_drop++;
                        gap_pend = 1;
                    end
                end
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
